// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-group display scanner: optional snapshot handshake, then per slot
// BLANK cycles all-off followed by PRESCALE cycles with one active-low group select.
module disp_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic       snap_ack,
  output logic       snap_req,
  output logic [3:0] sel_n,
  output logic [1:0] slot,
  output logic       blank,
  output logic       frame_done
);

  localparam int CMAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, SNAP, BLNK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          en_drop;

  function automatic logic [3:0] sel_for(input logic [1:0] s);
    case (s)
      2'd0:    sel_for = 4'b1110;
      2'd1:    sel_for = 4'b1101;
      2'd2:    sel_for = 4'b1011;
      default: sel_for = 4'b0111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      en_drop    <= 1'b0;
      snap_req   <= 1'b0;
      sel_n      <= 4'b1111;
      slot       <= 2'd0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          en_drop <= 1'b0;
          slot    <= 2'd0;
          sel_n   <= 4'b1111;
          blank   <= 1'b1;
          if (en) begin
            if (!hold) begin
              state    <= SNAP;
              snap_req <= 1'b1;
            end else begin
              state <= BLNK;
            end
          end
        end

        // The request is never withdrawn early; a disable seen here is remembered
        // and honoured once the latch side has acknowledged.
        SNAP: begin
          if (snap_ack) begin
            snap_req <= 1'b0;
            cnt      <= '0;
            en_drop  <= 1'b0;
            state    <= (en_drop || !en) ? IDLE : BLNK;
          end else if (!en) begin
            en_drop <= 1'b1;
          end
        end

        BLNK: begin
          if (!en) begin
            state <= IDLE;
            slot  <= 2'd0;
            cnt   <= '0;
          end else if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            sel_n <= sel_for(slot);
            blank <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHOW: begin
          if (!en) begin
            state <= IDLE;
            slot  <= 2'd0;
            cnt   <= '0;
            sel_n <= 4'b1111;
            blank <= 1'b1;
          end else if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            sel_n <= 4'b1111;
            blank <= 1'b1;
            if (slot == 2'd3) begin
              slot       <= 2'd0;
              frame_done <= 1'b1;
              if (!hold) begin
                state    <= SNAP;
                snap_req <= 1'b1;
              end else begin
                state <= BLNK;
              end
            end else begin
              slot  <= slot + 2'd1;
              state <= BLNK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed and random stimulus for disp_scan_ctrl against a frame-position reference model.
module tb_disp_scan_ctrl;

  localparam int P         = 4;
  localparam int B         = 2;
  localparam int SLOT_LEN  = P + B;
  localparam int FRAME_LEN = 4 * SLOT_LEN;

  logic       clk = 1'b0;
  logic       rst, en, hold, snap_ack;
  logic       snap_req, blank, frame_done;
  logic [3:0] sel_n;
  logic [1:0] slot;

  disp_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .snap_ack(snap_ack),
    .snap_req(snap_req), .sel_n(sel_n), .slot(slot), .blank(blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: idle, waiting on a snapshot, or at position m_pos within a scan frame.
  bit m_idle, m_snap, m_drop, m_done;
  int m_pos;
  int cyc = 0, last_done_cyc = 0, last_period = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_idle = 1'b1; m_snap = 1'b0; m_drop = 1'b0; m_done = 1'b0; m_pos = 0;
  endfunction

  function automatic void model_step();
    m_done = 1'b0;
    if (m_idle) begin
      if (en) begin
        m_idle = 1'b0; m_pos = 0; m_snap = !hold;
      end
    end else if (m_snap) begin
      if (!en) m_drop = 1'b1;
      if (snap_ack) begin
        m_snap = 1'b0; m_pos = 0;
        if (m_drop) m_idle = 1'b1;
        m_drop = 1'b0;
      end
    end else if (!en) begin
      m_idle = 1'b1;
    end else if (m_pos == FRAME_LEN - 1) begin
      m_done = 1'b1; m_pos = 0; m_snap = !hold;
    end else begin
      m_pos++;
    end
  endfunction

  function automatic logic [3:0] exp_sel();
    logic [3:0] one;
    one = 4'b0001;
    if (m_idle || m_snap || (m_pos % SLOT_LEN) < B) return 4'b1111;
    return ~(one << (m_pos / SLOT_LEN));
  endfunction

  function automatic int exp_slot();
    if (m_idle || m_snap) return 0;
    return m_pos / SLOT_LEN;
  endfunction

  task automatic chk_all();
    chk("sel_n", sel_n, exp_sel());
    chk("slot", slot, exp_slot());
    chk("blank", blank, exp_sel() == 4'b1111);
    chk("snap_req", snap_req, m_snap);
    chk("frame_done", frame_done, m_done);
    n_assert++;
    assert (sel_n inside {4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111}) else begin
      n_fail++;
      $error("FAIL sel_legal observed=%b expected=one-hot-low-or-1111", sel_n);
    end
    chk("blank_vs_sel", blank, sel_n == 4'b1111);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    if (frame_done) begin
      if (last_done_cyc > 0) last_period = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
    chk_all();
  endtask

  // Called at a falling edge; asserts rst between edges and checks outputs before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    chk_all();
    @(posedge clk);
    @(negedge clk);
    chk_all();
    rst = 1'b0;
    last_done_cyc = 0;
    last_period = 0;
  endtask

  task automatic run_until_show(input int s, input int c, input int limit);
    int k = 0;
    while (!(!m_idle && !m_snap && m_pos == s * SLOT_LEN + B + c) && k < limit) begin
      cycle();
      k++;
    end
    chk("wait_show_timeout", k < limit, 1);
  endtask

  task automatic run_until_snap(input int limit);
    int k = 0;
    while (!m_snap && k < limit) begin
      cycle();
      k++;
    end
    chk("wait_snap_timeout", k < limit, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hold = 1'b0; snap_ack = 1'b0;
    model_reset();
    @(negedge clk);
    chk_all();
    rst = 1'b0;

    // Free-running with immediate ack: 25-cycle frame.
    en = 1'b1; snap_ack = 1'b1;
    repeat (60) cycle();
    chk("period_snap", last_period, FRAME_LEN + 1);

    // Frozen display: no snapshot, 24-cycle frame.
    async_reset();
    hold = 1'b1; en = 1'b1;
    repeat (60) cycle();
    chk("period_hold", last_period, FRAME_LEN);

    // Acknowledge delayed by 5 cycles; ack noise outside SNAP afterwards.
    async_reset();
    hold = 1'b0; snap_ack = 1'b0; en = 1'b1;
    cycle();
    repeat (4) cycle();
    snap_ack = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) begin
      snap_ack = 1'($urandom % 2);
      cycle();
    end

    // Disable in the second cycle of slot 2 SHOW, then restart.
    snap_ack = 1'b1;
    run_until_show(2, 1, 100);
    en = 1'b0;
    cycle();
    en = 1'b1;
    repeat (30) cycle();

    // Disable while a snapshot is pending.
    snap_ack = 1'b0;
    run_until_snap(100);
    en = 1'b0;
    repeat (3) cycle();
    snap_ack = 1'b1;
    cycle();
    snap_ack = 1'b0;
    repeat (3) cycle();

    // Asynchronous reset mid-SHOW and mid-SNAP.
    en = 1'b1; snap_ack = 1'b1;
    run_until_show(1, 2, 100);
    async_reset();
    en = 1'b1; snap_ack = 1'b0;
    run_until_snap(10);
    cycle();
    async_reset();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 16) != 0;
      if ($urandom % 32 == 0) hold = ~hold;
      snap_ack = ($urandom % 3) == 0;
      if ($urandom % 400 == 0) async_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
